// File: rtl/rv_rr_packet_arbiter.sv
// rtl/rv_rr_packet_arbiter.sv - round-robin ready/valid arbiter with packet locking
// Registered single-stage output; grants are held until the owner's last beat is accepted.
module rv_rr_packet_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_valid,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    input  logic [NUM_REQ-1:0]        s_last,
    output logic [NUM_REQ-1:0]        s_ready,
    output logic                      m_valid,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last,
    output logic [ID_W-1:0]           m_id,
    input  logic                      m_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    lock_id;
    logic [ID_W-1:0]    cand;
    logic               cand_found;
    logic [ID_W-1:0]    grant;
    logic               grant_valid;
    logic               slot_free;
    logic               handshake;
    logic [DATA_W-1:0]  grant_data;
    logic               grant_last;
    logic [ID_W-1:0]    next_ptr;

    // Walk from the farthest offset back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        int idx;
        idx        = 0;
        cand       = '0;
        cand_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (s_valid[idx]) begin
                cand       = ID_W'(idx);
                cand_found = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = (state == LOCKED) ? lock_id : cand;
        grant_valid = (state == LOCKED) || cand_found;
        slot_free   = !m_valid || m_ready;
        s_ready     = '0;
        if (grant_valid && slot_free) begin
            s_ready[grant] = 1'b1;
        end
        handshake   = |(s_valid & s_ready);
        grant_data  = s_data[int'(grant)*DATA_W +: DATA_W];
        grant_last  = s_last[grant];
        next_ptr    = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
        end else begin
            if (handshake) begin
                m_valid <= 1'b1;
                m_data  <= grant_data;
                m_last  <= grant_last;
                m_id    <= grant;
                if (grant_last) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end else begin
                    state   <= LOCKED;
                    lock_id <= grant;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
